arith_quiz_ctrl: RTL and testbench
==================================

ARITH_QUIZ_CTRL -- requirements
Module: arith_quiz_ctrl

Interface
REQ-001 Parameter NUM_OPS, default 3, number of operators in play (2..4): 0 add, 1 sub, 2 mul, 3 div.
REQ-002 Parameter DIGIT_MAX, default 9, maximum operand value (1..9).
REQ-003 Parameter SHOW_CYCLES, default 1024, clk cycles each display item is held (>=1).
REQ-004 Parameter ROUNDS, default 9, questions per game (1..15).
REQ-005 Parameter TIMEOUT_CYCLES, default 65536, answer window in cycles; used only with QUIZ_TIMEOUT_EN.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  level; sampled in IDLE to begin a game.
REQ-009 switch  input  NUM_OPS  operator answer buttons, bit i selects operator i.
REQ-010 num_led  output  7  question display, abcdefg, 1 = segment lit.
REQ-011 point_led  output  7  score digit, abcdefg.
REQ-012 operator  output  2  operator of current question; valid while busy.
REQ-013 busy, done  output  1 each  game in progress / game finished.
REQ-014 correct, wrong  output  1 each  one-cycle verdict pulses.

Function
REQ-015 States: IDLE, GEN, SHOW_A, SHOW_B, SHOW_RT, SHOW_RU, WAIT_ANS, SCORE, DONE.
REQ-016 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle in all states; never all-zero.
REQ-017 IDLE -> GEN when start=1; busy=1 in every state except IDLE and DONE.
REQ-018 GEN (1 cycle): x = lfsr[3:0] mod (DIGIT_MAX+1), y = lfsr[7:4] mod (DIGIT_MAX+1); a = max(x,y), b = min(x,y); op = lfsr[1:0] mod NUM_OPS.
REQ-019 Div with b=0: b forced to 1; result = a/b truncated; sub never negative.
REQ-020 Result width 7 bits (max 81); tens = result/10, units = result mod 10.
REQ-021 SHOW_A, SHOW_B, SHOW_RT, SHOW_RU each hold num_led = segment code of a, b, tens, units for exactly SHOW_CYCLES cycles, then advance; SHOW_RU -> WAIT_ANS.
REQ-022 num_led blank (0) in IDLE, GEN, DONE; shows units digit throughout WAIT_ANS and SCORE.
REQ-023 Switch presses detected by rising edge against registered previous value; presses outside WAIT_ANS ignored.
REQ-024 WAIT_ANS: exactly one rising edge on bit i -> correct if operator i applied to (a,b) yields the displayed result (ties such as 2+2=2*2 accepted), else wrong.
REQ-025 Two or more simultaneous rising edges -> wrong.
REQ-026 Verdict -> SCORE (1 cycle): correct pulse and score+1 (saturating at 9), or wrong pulse and score unchanged; round counter +1.
REQ-027 SCORE -> GEN if rounds answered < ROUNDS, else DONE.
REQ-028 DONE: done=1, point_led holds final score until reset; start ignored.
REQ-029 point_led always equals segment code of current score, updated the cycle after score changes.

Reset
REQ-030 reset=1 takes priority over every transition, mid-game included: state IDLE, score 0, rounds 0, LFSR 8'hA5, switch history 0.
REQ-031 Registered outputs after reset: num_led 0, point_led 7'b1111110, operator 0, busy 0, done 0, correct 0, wrong 0.

Configuration
REQ-032 Macro QUIZ_TIMEOUT_EN defined: WAIT_ANS counter; no press within TIMEOUT_CYCLES -> wrong pulse, SCORE state as REQ-026; counter clears on entry to WAIT_ANS.
REQ-033 Macro undefined: no counter logic; WAIT_ANS waits indefinitely.

Structure
REQ-034 Package quiz_pkg holds state enum, operator enum, segment table constants (0-9, blank).
REQ-035 Sub-module seg7_decode (4-bit digit -> 7-bit abcdefg, >9 -> blank), instantiated for num_led and point_led.

Verification
REQ-036 Reset, start=1, LFSR gives a=7,b=3,op=sub -> num_led 7,3,0,4 each SHOW_CYCLES; switch[1] rise -> correct pulse, point_led 7'b0110000.
REQ-037 a=2,b=2,op=add, displayed 4 -> switch[2] rise -> correct (tie rule).
REQ-038 switch = 4'b0011 rising together in WAIT_ANS -> wrong pulse, score unchanged.
REQ-039 ROUNDS=2, two correct answers -> done=1, busy=0, point_led "2", later start ignored.
REQ-040 reset asserted during SHOW_B -> next cycle IDLE, num_led 0, point_led "0"; with QUIZ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no press -> wrong at cycle 16 of WAIT_ANS.

Source files
------------

// File: rtl/quiz_pkg.sv
// ============================================================================
// Module      : quiz_pkg
// Description : Shared state codes, operator enum, 7-segment table and the
//               operator evaluation helper for the arithmetic quiz block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package quiz_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_GEN     = 4'd1;
    localparam state_t S_SHOW_A  = 4'd2;
    localparam state_t S_SHOW_B  = 4'd3;
    localparam state_t S_SHOW_RT = 4'd4;
    localparam state_t S_SHOW_RU = 4'd5;
    localparam state_t S_WAIT    = 4'd6;
    localparam state_t S_SCORE   = 4'd7;
    localparam state_t S_DONE    = 4'd8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    // abcdefg, segment a in the MSB
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Operands arrive ordered a >= b, so subtraction never wraps; a zero
    // divisor is treated as one.
    function automatic logic [6:0] apply_op(input logic [1:0] op,
                                            input logic [3:0] a,
                                            input logic [3:0] b);
        logic [6:0] aw;
        logic [6:0] bw;
        aw = {3'b000, a};
        bw = {3'b000, b};
        case (op_e'(op))
            OP_ADD:  return aw + bw;
            OP_SUB:  return aw - bw;
            OP_MUL:  return aw * bw;
            OP_DIV:  return aw / ((bw == 7'd0) ? 7'd1 : bw);
            default: return 7'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/arith_quiz_ctrl_if.sv
// ============================================================================
// Module      : arith_quiz_ctrl_if
// Description : Player-facing bundle of the quiz: start, answer buttons,
//               displays and status/verdict flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arith_quiz_ctrl_if #(
    parameter int NUM_OPS = 3
);
    logic               start;
    logic [NUM_OPS-1:0] switch;
    logic [6:0]         num_led;
    logic [6:0]         point_led;
    logic [1:0]         operator;
    logic               busy;
    logic               done;
    logic               correct;
    logic               wrong;

    modport master (
        output start, switch,
        input  num_led, point_led, operator, busy, done, correct, wrong
    );

    modport slave (
        input  start, switch,
        output num_led, point_led, operator, busy, done, correct, wrong
    );
endinterface

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : 4-bit digit to abcdefg segment code; codes above 9 are blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import quiz_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/arith_quiz_ctrl.sv
// ============================================================================
// Module      : arith_quiz_ctrl
// Description : Arithmetic quiz: shows a, b and a two-digit result, player
//               names the operator; optional answer timeout via QUIZ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_quiz_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_OPS        = 3,
    parameter int DIGIT_MAX      = 9,
    parameter int SHOW_CYCLES    = 1024,
    parameter int ROUNDS         = 9,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             reset,
    arith_quiz_ctrl_if.slave quiz
);

    localparam int HOLD_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    generate
        if (NUM_OPS < 2 || NUM_OPS > 4 || DIGIT_MAX < 1 || DIGIT_MAX > 9 ||
            SHOW_CYCLES < 1 || ROUNDS < 1 || ROUNDS > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("arith_quiz_ctrl: parameter out of range");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [7:0]         lfsr_q;
    logic [3:0]         a_q, b_q, tens_q, units_q;
    logic [1:0]         op_q;
    logic [6:0]         res_q;
    logic [3:0]         score_q, rounds_q;
    logic [NUM_OPS-1:0] sw_q;
    logic               correct_q, wrong_q, busy_q, done_q;
    logic [6:0]         num_led_q, point_led_q;

    logic [3:0]         w_x, w_y, w_a, w_b, w_num_digit;
    logic [1:0]         w_op, w_sel;
    logic [6:0]         w_res, w_num_seg, w_point_seg;
    logic [NUM_OPS-1:0] w_rise;
    logic               w_press, w_good, w_correct, w_wrong, w_timeout;

    // Question drawn from the LFSR value present during GEN
    always_comb begin
        w_x  = 4'(32'(lfsr_q[3:0]) % (DIGIT_MAX + 1));
        w_y  = 4'(32'(lfsr_q[7:4]) % (DIGIT_MAX + 1));
        w_a  = (w_x > w_y) ? w_x : w_y;
        w_b  = (w_x > w_y) ? w_y : w_x;
        w_op = 2'(32'(lfsr_q[1:0]) % NUM_OPS);
        if (w_op == OP_DIV && w_b == 4'd0) begin
            w_b = 4'd1;
        end
        w_res = apply_op(w_op, w_a, w_b);
    end

    always_comb begin
        w_rise = quiz.switch & ~sw_q;
        w_sel  = 2'd0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (w_rise[i]) begin
                w_sel = 2'(i);
            end
        end
        w_press   = |w_rise;
        w_good    = $onehot(w_rise) && (apply_op(w_sel, a_q, b_q) == res_q);
        w_correct = (state_q == S_WAIT) && w_press && w_good;
        w_wrong   = (state_q == S_WAIT) && ((w_press && !w_good) || w_timeout);
    end

`ifdef QUIZ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Held at zero outside WAIT_ANS, so every answer window starts fresh
    always_ff @(posedge clk) begin
        if (reset || state_q != S_WAIT) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign w_timeout = (state_q == S_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (quiz.start) begin
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                state_d = S_SHOW_A;
                hold_d  = '0;
            end
            S_SHOW_A, S_SHOW_B, S_SHOW_RT, S_SHOW_RU: begin
                if (hold_q == HOLD_W'(SHOW_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = (state_q == S_SHOW_RU) ? S_WAIT : state_q + 4'd1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_WAIT: begin
                if (w_correct || w_wrong) begin
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                state_d = (rounds_q == 4'(ROUNDS)) ? S_DONE : S_GEN;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_SHOW_A:                   w_num_digit = a_q;
            S_SHOW_B:                   w_num_digit = b_q;
            S_SHOW_RT:                  w_num_digit = tens_q;
            S_SHOW_RU, S_WAIT, S_SCORE: w_num_digit = units_q;
            default:                    w_num_digit = DIGIT_BLANK;
        endcase
    end

    seg7_decode u_num_seg (
        .digit_i (w_num_digit),
        .seg_o   (w_num_seg)
    );

    seg7_decode u_point_seg (
        .digit_i (score_q),
        .seg_o   (w_point_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            lfsr_q      <= 8'hA5;
            a_q         <= '0;
            b_q         <= '0;
            tens_q      <= '0;
            units_q     <= '0;
            op_q        <= '0;
            res_q       <= '0;
            score_q     <= '0;
            rounds_q    <= '0;
            sw_q        <= '0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            num_led_q   <= SEG_BLANK;
            point_led_q <= SEG_0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            sw_q    <= quiz.switch;
            if (state_q == S_GEN) begin
                a_q     <= w_a;
                b_q     <= w_b;
                op_q    <= w_op;
                res_q   <= w_res;
                tens_q  <= 4'(w_res / 7'd10);
                units_q <= 4'(w_res % 7'd10);
            end
            if (w_correct && score_q != 4'd9) begin
                score_q <= score_q + 4'd1;
            end
            if (w_correct || w_wrong) begin
                rounds_q <= rounds_q + 4'd1;
            end
            correct_q   <= w_correct;
            wrong_q     <= w_wrong;
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
            num_led_q   <= w_num_seg;
            point_led_q <= w_point_seg;
        end
    end

    assign quiz.num_led   = num_led_q;
    assign quiz.point_led = point_led_q;
    assign quiz.operator  = op_q;
    assign quiz.busy      = busy_q;
    assign quiz.done      = done_q;
    assign quiz.correct   = correct_q;
    assign quiz.wrong     = wrong_q;

endmodule

`default_nettype wire

// File: tb/tb_arith_quiz_ctrl.sv
// ============================================================================
// Module      : tb_arith_quiz_ctrl
// Description : Directed bench for arith_quiz_ctrl with a verdict scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_quiz_ctrl;

    localparam int S  = 3;
    localparam int RN = 2;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arith_quiz_ctrl_if #(.NUM_OPS(4)) qif ();

    arith_quiz_ctrl #(
        .NUM_OPS        (4),
        .DIGIT_MAX      (9),
        .SHOW_CYCLES    (S),
        .ROUNDS         (RN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .quiz  (qif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit good;
        int score;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [7:0] nxt(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [7:0] m;
    always @(posedge clk) begin
        if (reset) m <= 8'hA5;
        else       m <= nxt(m);
    end

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic decode(input logic [7:0] g, output int a, output int b,
                          output int op, output int res);
        int x, y;
        x  = int'(g[3:0]) % 10;
        y  = int'(g[7:4]) % 10;
        a  = (x > y) ? x : y;
        b  = (x > y) ? y : x;
        op = int'(g[1:0]);
        if (op == 3 && b == 0) b = 1;
        case (op)
            0:       res = a + b;
            1:       res = a - b;
            2:       res = a * b;
            default: res = a / b;
        endcase
    endtask

    // Entered at the negedge of the GEN cycle; leaves at the first WAIT_ANS negedge
    task automatic show_round(input int a, input int b, input int tens, input int units, input int op);
        int d[4];
        d[0] = a; d[1] = b; d[2] = tens; d[3] = units;
        for (int c = 1; c <= 4 * S + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("gen_blank", qif.num_led, 7'b0);
                chk("busy_in_game", qif.busy, 1'b1);
            end
            for (int k = 0; k < 4; k++) begin
                if (c == k * S + 2)     chk("item_first", qif.num_led, seg(d[k]));
                if (c == k * S + S + 1) chk("item_last",  qif.num_led, seg(d[k]));
            end
        end
        chk("operator", qif.operator, op);
    endtask

    task automatic answer(input logic [3:0] pat, input bit good, input int score);
        exp_q.push_back('{good, score});
        qif.switch = pat;
        @(negedge clk);
        qif.switch = 4'b0;
        @(negedge clk);
    endtask

    task automatic start_target(input int ta, input int tb, input int top);
        int a, b, op, res;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            decode(nxt(m), a, b, op, res);
            if (a == ta && b == tb && op == top) begin
                qif.start = 1'b1;
                found = 1'b1;
            end
            @(negedge clk);
        end
        qif.start = 1'b0;
        if (!found) begin
            $display("FAIL start_target: got none expected a=%0d b=%0d op=%0d", ta, tb, top);
            $fatal(1, "target question never produced");
        end
    endtask

    task automatic start_any();
        qif.start = 1'b1;
        @(negedge clk);
        qif.start = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor: every verdict pulse consumes one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qif.correct === 1'b1 || qif.wrong === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("verdict_unexpected", {qif.correct, qif.wrong}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("verdict_correct", qif.correct, e.good);
                    chk("verdict_wrong", qif.wrong, !e.good);
                    @(negedge clk);
                    chk("point_after_verdict", qif.point_led, seg(e.score));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, op, res;
        qif.start  = 1'b0;
        qif.switch = 4'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_num_led",   qif.num_led,   7'b0);
        chk("rst_point_led", qif.point_led, 7'b1111110);
        chk("rst_operator",  qif.operator,  2'd0);
        chk("rst_busy",      qif.busy,      1'b0);
        chk("rst_done",      qif.done,      1'b0);
        chk("rst_correct",   qif.correct,   1'b0);
        chk("rst_wrong",     qif.wrong,     1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Game 1: 7-3=4 answered sub, then a random round answered correctly
        start_target(7, 3, 1);
        show_round(7, 3, 0, 4, 1);
        answer(4'b0010, 1'b1, 1);
        decode(m, a, b, op, res);
        show_round(a, b, res / 10, res % 10, op);
        answer(4'(1 << op), 1'b1, 2);
        chk("g1_done",  qif.done, 1'b1);
        chk("g1_busy",  qif.busy, 1'b0);
        chk("g1_point", qif.point_led, 7'b1101101);
        qif.start = 1'b1;
        repeat (10) @(negedge clk);
        chk("done_hold",       qif.done, 1'b1);
        chk("done_start_busy", qif.busy, 1'b0);
        chk("done_point",      qif.point_led, 7'b1101101);
        chk("done_num_blank",  qif.num_led, 7'b0);
        qif.start = 1'b0;
        reset_pulse();

        // Game 2: 2+2 answered mul (tie), then a double press
        start_target(2, 2, 0);
        show_round(2, 2, 0, 4, 0);
        answer(4'b0100, 1'b1, 1);
        decode(m, a, b, op, res);
        show_round(a, b, res / 10, res % 10, op);
        answer(4'b0011, 1'b0, 1);
        chk("g2_done",  qif.done, 1'b1);
        chk("g2_point", qif.point_led, 7'b0110000);
        reset_pulse();

        // Game 3: reset lands in SHOW_B of round two
        start_any();
        decode(m, a, b, op, res);
        show_round(a, b, res / 10, res % 10, op);
        answer(4'(1 << op), 1'b1, 1);
        decode(m, a, b, op, res);
        repeat (S + 2) @(negedge clk);
        chk("mid_show_b", qif.num_led, seg(b));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_num_led", qif.num_led,   7'b0);
        chk("midrst_point",   qif.point_led, 7'b1111110);
        chk("midrst_busy",    qif.busy,      1'b0);
        chk("midrst_oper",    qif.operator,  2'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", qif.busy, 1'b0);

        // Game 4: nobody answers
        start_any();
        decode(m, a, b, op, res);
        show_round(a, b, res / 10, res % 10, op);
`ifdef QUIZ_TIMEOUT_EN
        exp_q.push_back('{1'b0, 0});
        repeat (TO - 1) @(negedge clk);
        chk("timeout_early", qif.wrong, 1'b0);
        @(negedge clk);
        chk("timeout_pulse", qif.wrong, 1'b1);
        @(negedge clk);
`else
        repeat (40) @(negedge clk);
        chk("wait_forever_busy", qif.busy, 1'b1);
        chk("wait_forever_led",  qif.num_led, seg(res % 10));
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
